// File: rtl/bus_arbiter_if.sv
// Shared single-port memory bus: registered request side, one-cycle ack.
interface bus_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Arbiter side issues requests, memory side answers them.
  modport master (output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/bus_arbiter.sv
// Merges instruction-fetch (two-word beats) and data accesses onto one
// memory bus. Results are held until the pipeline advances.
module bus_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic [31:0] inst_rdata_2,
  output logic        inst_stall,
  input  logic        data_ce,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  input  logic        pipe_hold,
  bus_arbiter_if.master mem
);

  typedef enum logic [1:0] {IDLE, DATA, INST1, INST2} state_t;

  state_t      state;
  logic        data_valid, inst_valid;
  logic        dpend, ipend, adv, ack;
  logic [3:0]  d_be;
  logic [31:0] inst_addr_hi;

  assign dpend        = data_ce & ~data_valid;
  assign ipend        = inst_ce & ~inst_valid;
  assign data_stall   = dpend;
  assign inst_stall   = ipend;
  assign adv          = ~inst_stall & ~data_stall & ~pipe_hold;
  // An ack with no request outstanding is stray and ignored.
  assign ack          = mem.mem_ack & mem.mem_req;
  // Reads always fetch the full word.
  assign d_be         = data_we ? data_be : 4'hF;
  assign inst_addr_hi = inst_addr + 32'd4;

  // Arbitration FSM; bus outputs are loaded with the next beat so they stay
  // stable for the whole request and beats chain with no idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      data_valid   <= 1'b0;
      inst_valid   <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_we   <= 1'b0;
      mem.mem_be   <= 4'h0;
      mem.mem_addr <= 32'h0;
      mem.mem_wdata <= 32'h0;
      inst_rdata   <= 32'h0;
      inst_rdata_2 <= 32'h0;
      data_rdata   <= 32'h0;
    end else begin
      // Results are consumed when the pipeline advances or the request drops.
      if (adv) begin
        data_valid <= 1'b0;
        inst_valid <= 1'b0;
      end else begin
        if (!data_ce) data_valid <= 1'b0;
        if (!inst_ce) inst_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (dpend && (DATA_FIRST || !ipend)) begin
            state         <= DATA;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= data_we;
            mem.mem_be    <= d_be;
            mem.mem_addr  <= data_addr;
            mem.mem_wdata <= data_wdata;
          end else if (ipend) begin
            state        <= INST1;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_be   <= 4'hF;
            mem.mem_addr <= inst_addr;
          end
        end
        DATA: begin
          if (ack) begin
            if (!data_we) data_rdata <= mem.mem_rdata;
            data_valid <= 1'b1;
            if (ipend) begin
              state        <= INST1;
              mem.mem_we   <= 1'b0;
              mem.mem_be   <= 4'hF;
              mem.mem_addr <= inst_addr;
            end else begin
              state       <= IDLE;
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
            end
          end
        end
        INST1: begin
          if (ack) begin
            inst_rdata   <= mem.mem_rdata;
            state        <= INST2;
            mem.mem_addr <= inst_addr_hi;
          end
        end
        INST2: begin
          if (ack) begin
            inst_rdata_2 <= mem.mem_rdata;
            inst_valid   <= 1'b1;
            if (dpend) begin
              state         <= DATA;
              mem.mem_we    <= data_we;
              mem.mem_be    <= d_be;
              mem.mem_addr  <= data_addr;
              mem.mem_wdata <= data_wdata;
            end else begin
              state       <= IDLE;
              mem.mem_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: memory model with wait states checks every beat
// against a queue of expected beats; results checked at completion.
module tb_bus_arbiter;

  logic        clk, rst;
  logic        inst_ce, data_ce, data_we, pipe_hold;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_be;
  logic [31:0] inst_rdata, inst_rdata_2, data_rdata;
  logic        inst_stall, data_stall;

  bus_arbiter_if mem ();

  bus_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_ce(inst_ce), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_rdata_2(inst_rdata_2), .inst_stall(inst_stall),
    .data_ce(data_ce), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_stall(data_stall),
    .pipe_hold(pipe_hold), .mem(mem)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  beat_t sb[$];
  int checks = 0, errors = 0;
  int wait_n = 0, wcnt = 0, wr_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memv(input logic [31:0] a);
    if (a == 32'h8000_0010) return 32'h1234_5678;
    return (a ^ 32'hA5A5_0000) + 32'h0101_0101;
  endfunction

  task automatic push(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd);
    beat_t b;
    b.addr = a; b.we = we; b.be = be; b.wdata = wd;
    sb.push_back(b);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory model: checks each requested beat against the queue head every
  // cycle (so it also catches unstable requests), acks after wait_n cycles.
  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 32'h0;
  end
  always @(negedge clk) begin
    if (mem.mem_req && !rst) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_req", mem.mem_addr, 32'hxxxx_xxxx);
      end else begin
        chk("beat_addr", mem.mem_addr, sb[0].addr);
        chk("beat_we", 32'(mem.mem_we), 32'(sb[0].we));
        chk("beat_be", 32'(mem.mem_be), 32'(sb[0].be));
        if (sb[0].we) chk("beat_wdata", mem.mem_wdata, sb[0].wdata);
      end
      if (wcnt == wait_n) begin
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = memv(mem.mem_addr);
        if (mem.mem_we) wr_cnt++;
        if (sb.size() != 0) void'(sb.pop_front());
        wcnt = 0;
      end else begin
        mem.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem.mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  initial begin
    int stall_cnt, a0, a4, n;
    logic [31:0] prev;
    rst = 1'b1; inst_ce = 0; data_ce = 0; data_we = 0; pipe_hold = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_be = 0;
    tick; tick;
    chk("rst_req", 32'(mem.mem_req), 0);
    chk("rst_we", 32'(mem.mem_we), 0);
    chk("rst_be", 32'(mem.mem_be), 0);
    chk("rst_addr", mem.mem_addr, 0);
    chk("rst_wdata", mem.mem_wdata, 0);
    chk("rst_irdata", inst_rdata, 0);
    chk("rst_irdata2", inst_rdata_2, 0);
    chk("rst_drdata", data_rdata, 0);
    rst = 1'b0;
    tick;

    // Zero-wait data read.
    push(32'h8000_0010, 1'b0, 4'hF, 32'h0);
    data_addr = 32'h8000_0010; data_we = 0; data_be = 4'b0001; data_ce = 1; #1;
    chk("t1_req_c0", 32'(mem.mem_req), 0);
    chk("t1_stall_c0", 32'(data_stall), 1);
    tick;
    chk("t1_req_c1", 32'(mem.mem_req), 1);
    chk("t1_stall_c1", 32'(data_stall), 1);
    tick;
    chk("t1_req_c2", 32'(mem.mem_req), 0);
    chk("t1_stall_c2", 32'(data_stall), 0);
    chk("t1_rdata", data_rdata, 32'h1234_5678);
    data_ce = 0;
    tick;

    // Fetch and data read together: data first, then both fetch beats.
    push(32'h200, 1'b0, 4'hF, 32'h0);
    push(32'h1000, 1'b0, 4'hF, 32'h0);
    push(32'h1004, 1'b0, 4'hF, 32'h0);
    data_addr = 32'h200; inst_addr = 32'h1000; data_ce = 1; inst_ce = 1; #1;
    tick; tick; tick;
    chk("t2_istall_c3", 32'(inst_stall), 1);
    chk("t2_dstall_c3", 32'(data_stall), 0);
    tick;
    chk("t2_istall_c4", 32'(inst_stall), 0);
    chk("t2_dstall_c4", 32'(data_stall), 0);
    chk("t2_drdata", data_rdata, memv(32'h200));
    chk("t2_irdata", inst_rdata, memv(32'h1000));
    chk("t2_irdata2", inst_rdata_2, memv(32'h1004));
    data_ce = 0; inst_ce = 0;
    tick;

    // Fetch with two wait states per beat.
    wait_n = 2;
    push(32'h1000, 1'b0, 4'hF, 32'h0);
    push(32'h1004, 1'b0, 4'hF, 32'h0);
    inst_addr = 32'h1000; inst_ce = 1; #1;
    stall_cnt = 0; a0 = 0; a4 = 0;
    for (int c = 0; c < 20; c++) begin
      if (inst_stall) stall_cnt++;
      if (mem.mem_req && mem.mem_addr == 32'h1000) a0++;
      if (mem.mem_req && mem.mem_addr == 32'h1004) a4++;
      if (!inst_stall) break;
      tick;
    end
    chk("t3_stall_cycles", 32'(stall_cnt), 7);
    chk("t3_addr0_cycles", 32'(a0), 3);
    chk("t3_addr4_cycles", 32'(a4), 3);
    chk("t3_irdata2", inst_rdata_2, memv(32'h1004));
    inst_ce = 0; wait_n = 0;
    tick;

    // Write completing under pipe_hold: one beat only, read data untouched.
    prev = memv(32'h200);
    wr_cnt = 0;
    push(32'h300, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    data_addr = 32'h300; data_we = 1; data_be = 4'b0011; data_wdata = 32'hDEAD_BEEF;
    data_ce = 1; pipe_hold = 1; #1;
    tick; tick;
    for (int c = 0; c < 5; c++) begin
      chk("t4_dstall_hold", 32'(data_stall), 0);
      chk("t4_req_hold", 32'(mem.mem_req), 0);
      tick;
    end
    chk("t4_writes", 32'(wr_cnt), 1);
    chk("t4_drdata", data_rdata, prev);
    pipe_hold = 0; data_ce = 0; data_we = 0;
    tick; tick;
    chk("t4_writes_after", 32'(wr_cnt), 1);

    // Fetch at top of address space: second beat wraps to zero.
    push(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0);
    push(32'h0000_0000, 1'b0, 4'hF, 32'h0);
    inst_addr = 32'hFFFF_FFFC; inst_ce = 1; #1;
    tick; tick; tick;
    chk("t5_istall", 32'(inst_stall), 0);
    chk("t5_irdata", inst_rdata, memv(32'hFFFF_FFFC));
    chk("t5_irdata2", inst_rdata_2, memv(32'h0));
    inst_ce = 0;
    tick;

    // Reset while the second fetch beat is waiting, then a clean fetch.
    wait_n = 3;
    push(32'h2000, 1'b0, 4'hF, 32'h0);
    push(32'h2004, 1'b0, 4'hF, 32'h0);
    inst_addr = 32'h2000; inst_ce = 1; #1;
    n = 0;
    while (!(mem.mem_req && mem.mem_addr == 32'h2004) && n < 30) begin
      tick;
      n++;
    end
    chk("t6_reach_beat2", 32'(n < 30), 1);
    tick;
    rst = 1;
    tick;
    chk("t6_req", 32'(mem.mem_req), 0);
    chk("t6_addr", mem.mem_addr, 0);
    chk("t6_be", 32'(mem.mem_be), 0);
    chk("t6_wdata", mem.mem_wdata, 0);
    chk("t6_irdata", inst_rdata, 0);
    chk("t6_irdata2", inst_rdata_2, 0);
    chk("t6_drdata", data_rdata, 0);
    sb.delete();
    inst_ce = 0; rst = 0; wait_n = 0;
    tick;
    push(32'h3000, 1'b0, 4'hF, 32'h0);
    push(32'h3004, 1'b0, 4'hF, 32'h0);
    inst_addr = 32'h3000; inst_ce = 1; #1;
    tick; tick; tick;
    chk("t6_post_istall", 32'(inst_stall), 0);
    chk("t6_post_irdata", inst_rdata, memv(32'h3000));
    chk("t6_post_irdata2", inst_rdata_2, memv(32'h3004));
    inst_ce = 0;
    tick;
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
